// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch state type, PC step and decode funct codes
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_VALID = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int INSTR_BYTES = 4;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_DIV = 6'h1A;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection plus range and alignment flags for the current PC
module fetch_pc_gen import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PROG_BYTES = 32'd32
) (
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        advance_i,
  input  logic        start_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o,
  output logic        prog_end_o
);
  assign next_pc_o    = start_i ? RESET_PC : redirect_i ? redirect_addr_i : advance_i ? pc_i + PC_STEP : pc_i;
  assign misaligned_o = |pc_i[1:0];
  assign prog_end_o   = pc_i >= PROG_BYTES;
endmodule

// File: rtl/instruction_fetch_ctrl.sv
// instruction_fetch_ctrl: PC owner and fetch sequencer feeding decode through a valid/ready register
module instruction_fetch_ctrl import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PROG_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] readAddress,
  input  logic [31:0] Instruction,
  output logic [31:0] instrOut,
  output logic [31:0] pcOut,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectAddr,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc_out_q, pc_out_d;
  logic active, start_go, redir_go, fetch_now, advance, pc_mis, pc_end;
  assign active    = state_q == S_FETCH || state_q == S_VALID;
  assign start_go  = start && !active;
  assign redir_go  = redirect && active;
  assign fetch_now = !redir_go && (state_q == S_FETCH || (state_q == S_VALID && instrReady));
  assign advance   = fetch_now && !pc_end && !pc_mis;
  fetch_pc_gen #(.RESET_PC(RESET_PC), .PROG_BYTES(PROG_BYTES)) u_pc_gen (
    .pc_i(pc_q),
    .redirect_i(redir_go),
    .redirect_addr_i(redirectAddr),
    .advance_i(advance),
    .start_i(start_go),
    .next_pc_o(pc_d),
    .misaligned_o(pc_mis),
    .prog_end_o(pc_end)
  );
  // next state and capture of the fetched word; redirect flushes back to FETCH
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    if (start_go || redir_go) state_d = S_FETCH;
    else if (fetch_now) state_d = pc_end ? S_DONE : pc_mis ? S_ERROR : S_VALID;
    if (advance) begin
      instr_d  = Instruction;
      pc_out_d = pc_q;
    end
  end
  // state, PC and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end
  assign readAddress = pc_q;
  assign instrOut    = instr_q;
  assign pcOut       = pc_out_q;
  assign instrValid  = state_q == S_VALID;
  assign busy        = active;
  assign done        = state_q == S_DONE;
  assign misaligned  = state_q == S_ERROR;
endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// tb_instruction_fetch_ctrl: vector table, directed corner sequences and random run against a reference model
module tb_instruction_fetch_ctrl;
  logic clk, reset, start, instrReady, redirect;
  logic [31:0] readAddress, Instruction, instrOut, pcOut, redirectAddr;
  logic instrValid, busy, done, misaligned;
  logic [7:0] mem [32];
  logic [31:0] prog [8];
  logic [4:0] ma;
  int nvec = 0, nmis = 0;
  logic [31:0] m_pc, m_instr, m_pcout;
  logic m_run, m_hold, m_done, m_err;

  typedef struct {
    logic st, rdy, rd;
    logic [31:0] ra;
    logic ev, eb, ed, em;
    logic [31:0] epc, ein, eaddr;
  } vec_t;
  vec_t tbl [10];

  instruction_fetch_ctrl #(.RESET_PC(32'h0), .PROG_BYTES(32'd32)) dut (
    .clk(clk), .reset(reset), .start(start), .readAddress(readAddress),
    .Instruction(Instruction), .instrOut(instrOut), .pcOut(pcOut),
    .instrValid(instrValid), .instrReady(instrReady), .redirect(redirect),
    .redirectAddr(redirectAddr), .busy(busy), .done(done), .misaligned(misaligned)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // big-endian combinational instruction memory
  always_comb begin
    ma = readAddress[4:0];
    Instruction = {mem[ma], mem[ma + 5'd1], mem[ma + 5'd2], mem[ma + 5'd3]};
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[a[4:0]], mem[a[4:0] + 5'd1], mem[a[4:0] + 5'd2], mem[a[4:0] + 5'd3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic mreset();
    m_pc = 0; m_instr = 0; m_pcout = 0;
    m_run = 0; m_hold = 0; m_done = 0; m_err = 0;
  endtask

  // one clock of the behavioural fetcher: idle/finished runs only react to start
  task automatic mstep();
    if (!m_run) begin
      if (start) begin
        m_pc = 0; m_run = 1; m_hold = 0; m_done = 0; m_err = 0;
      end
    end else if (redirect) begin
      m_pc = redirectAddr; m_hold = 0;
    end else if (!m_hold || instrReady) begin
      if (m_pc >= 32) begin
        m_run = 0; m_hold = 0; m_done = 1;
      end else if (m_pc % 4 != 0) begin
        m_run = 0; m_hold = 0; m_err = 1;
      end else begin
        m_instr = word_at(m_pc); m_pcout = m_pc; m_pc = m_pc + 4; m_hold = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep();
    #1;
  endtask

  task automatic do_reset();
    start = 0; redirect = 0; instrReady = 1; redirectAddr = 0;
    reset = 1;
    mreset();
    #2;
    reset = 0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_valid"}, {31'b0, instrValid}, {31'b0, m_hold});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, m_run});
    chk({tag, "_done"}, {31'b0, done}, {31'b0, m_done});
    chk({tag, "_mis"}, {31'b0, misaligned}, {31'b0, m_err});
    chk({tag, "_addr"}, readAddress, m_pc);
    chk({tag, "_pcout"}, pcOut, m_pcout);
    chk({tag, "_instr"}, instrOut, m_instr);
  endtask

  initial begin
    prog[0] = 32'h01CAB020; prog[1] = 32'h01CAB022; prog[2] = 32'h71CAB002; prog[3] = 32'h01CAB01A;
    prog[4] = 32'h01CAB025; prog[5] = 32'h01CAB024; prog[6] = 32'h01CAB02A; prog[7] = 32'h01CAB000;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) mem[4*i+j] = prog[i][31-8*j -: 8];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
    for (int i = 1; i < 9; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'(4*(i-1)), prog[i-1], 32'(4*i)};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd28, 32'h01CAB000, 32'd32};

    @(posedge clk); #1;
    do_reset();
    chk1("rst_valid", instrValid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mis", misaligned, 1'b0);
    chk("rst_instr", instrOut, 32'h0);
    chk("rst_pcout", pcOut, 32'h0);
    chk("rst_addr", readAddress, 32'h0);

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].st; instrReady = tbl[i].rdy; redirect = tbl[i].rd; redirectAddr = tbl[i].ra;
      cyc();
      chk1($sformatf("seq%0d_valid", i), instrValid, tbl[i].ev);
      chk1($sformatf("seq%0d_busy", i), busy, tbl[i].eb);
      chk1($sformatf("seq%0d_done", i), done, tbl[i].ed);
      chk1($sformatf("seq%0d_mis", i), misaligned, tbl[i].em);
      chk($sformatf("seq%0d_pcout", i), pcOut, tbl[i].epc);
      chk($sformatf("seq%0d_instr", i), instrOut, tbl[i].ein);
      chk($sformatf("seq%0d_addr", i), readAddress, tbl[i].eaddr);
    end
    start = 0;
    cyc();
    chk1("done_sticky", done, 1'b1);

    do_reset();
    start = 1; cyc(); start = 0;
    cyc(); cyc(); cyc();
    chk("bp_pre_pcout", pcOut, 32'd8);
    instrReady = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_instr", instrOut, 32'h71CAB002);
      chk("bp_addr", readAddress, 32'd12);
      chk("bp_pcout", pcOut, 32'd8);
      chk1("bp_valid", instrValid, 1'b1);
    end
    instrReady = 1;
    cyc();
    chk("bp_release_pcout", pcOut, 32'd12);
    chk("bp_release_instr", instrOut, 32'h01CAB01A);

    do_reset();
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    chk("rd_pre_pcout", pcOut, 32'd4);
    redirect = 1; redirectAddr = 32'h14;
    cyc();
    redirect = 0;
    chk1("rd_flush_valid", instrValid, 1'b0);
    chk("rd_flush_addr", readAddress, 32'h14);
    cyc();
    chk1("rd_valid", instrValid, 1'b1);
    chk("rd_instr", instrOut, 32'h01CAB024);
    chk("rd_pcout", pcOut, 32'd20);
    cyc();
    chk("rd_pc24", pcOut, 32'd24);
    cyc();
    chk("rd_pc28", pcOut, 32'd28);
    cyc();
    chk1("rd_done", done, 1'b1);

    do_reset();
    start = 1; cyc(); start = 0;
    cyc();
    redirect = 1; redirectAddr = 32'h06;
    cyc();
    redirect = 0;
    chk1("mis_flush_valid", instrValid, 1'b0);
    chk1("mis_not_yet", misaligned, 1'b0);
    cyc();
    chk1("mis_flag", misaligned, 1'b1);
    chk1("mis_valid", instrValid, 1'b0);
    chk1("mis_busy", busy, 1'b0);
    redirect = 1; redirectAddr = 32'h0;
    cyc();
    chk1("mis_sticky", misaligned, 1'b1);
    chk("mis_redirect_ignored", readAddress, 32'h06);
    start = 1;
    cyc();
    start = 0; redirect = 0;
    chk1("mis_restart_clear", misaligned, 1'b0);
    chk1("mis_restart_busy", busy, 1'b1);
    cyc();
    chk("mis_restart_pcout", pcOut, 32'd0);
    chk1("mis_restart_valid", instrValid, 1'b1);

    do_reset();
    start = 1; cyc(); start = 0;
    cyc(); cyc(); cyc(); cyc();
    chk("ar_pre_pcout", pcOut, 32'd12);
    #2;
    reset = 1;
    #1;
    chk1("ar_valid", instrValid, 1'b0);
    chk("ar_instr", instrOut, 32'h0);
    chk("ar_pcout", pcOut, 32'h0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_done", done, 1'b0);
    chk1("ar_mis", misaligned, 1'b0);
    chk("ar_addr", readAddress, 32'h0);
    mreset();
    #1;
    reset = 0;

    @(posedge clk); #1;
    start = 1; cyc(); start = 0;
    cyc();
    redirect = 1; instrReady = 1; redirectAddr = 32'h18;
    cyc();
    redirect = 0;
    chk1("sr_flush_valid", instrValid, 1'b0);
    cyc();
    chk1("sr_valid", instrValid, 1'b1);
    chk("sr_instr", instrOut, 32'h01CAB02A);
    chk("sr_pcout", pcOut, 32'd24);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 6) == 0;
      instrReady = ($urandom % 10) < 7;
      redirect = ($urandom % 7) == 0;
      redirectAddr = ($urandom % 5 == 0) ? 32'($urandom % 40) : 32'(($urandom % 10) * 4);
      cyc();
      cmp_model("rnd");
      if (i == 300) begin
        reset = 1;
        mreset();
        #1;
        cmp_model("rnd_reset");
        reset = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
